// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer
// ----------------------------------------------------------------------------
// Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out MSB first, one bit per clock.
// A new word may be accepted on the final bit of the current one, giving
// gap-free back-to-back streaming.
//
// Optional build macro: PISO_PARITY_EN
//   When defined, one even-parity bit (XOR of the accepted word) follows the
//   last data bit; done and the back-to-back accept window move onto that
//   parity cycle. The port list is identical in both builds.
//
// Parameters:
//   WIDTH  data word width in bits (2..32)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din         parallel word to transmit
//   load_valid  din is valid this cycle
//   load_ready  block can accept a word this cycle
//   sout        serial data bit
//   sout_valid  sout carries a data (or parity) bit this cycle
//   busy        transfer in progress
//   done        one-cycle pulse on the final bit of a word
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    // Bit-counter width, derived from WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_SHIFT  = 2'd1
    } state_t;

`ifdef PISO_PARITY_EN
    // Even parity of a data word.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    state_t             state_r;
    logic [WIDTH-1:0]   shreg_r;
    logic [CNT_W-1:0]   cnt_r;

    state_t             state_s;
    logic [WIDTH-1:0]   shreg_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               accept_s;

    logic               sout_s;
    logic               sout_valid_s;
    logic               busy_s;
    logic               done_s;
    logic               load_ready_s;

`ifdef PISO_PARITY_EN
    logic               parity_r;
    logic               parity_s;
`endif

    // A word is taken only when the registered ready is high.
    assign accept_s = load_valid && load_ready;

    // Next-state computation: state, shift register, counter (and parity).
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
`ifdef PISO_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    shreg_s = din;
                    cnt_s   = CNT_W'(WIDTH - 1);
`ifdef PISO_PARITY_EN
                    parity_s = even_parity(din);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
                    cnt_s   = cnt_r - CNT_W'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    // Data exhausted: one parity cycle follows.
                    state_s = ST_PARITY;
                    shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
`else
                    // Last bit: reload for gap-free streaming, else go idle.
                    if (accept_s) begin
                        state_s = ST_SHIFT;
                        shreg_s = din;
                        cnt_s   = CNT_W'(WIDTH - 1);
                    end else begin
                        state_s = ST_IDLE;
                        shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (accept_s) begin
                    state_s  = ST_SHIFT;
                    shreg_s  = din;
                    cnt_s    = CNT_W'(WIDTH - 1);
                    parity_s = even_parity(din);
                end else begin
                    state_s = ST_IDLE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                shreg_s = {WIDTH{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so
    // the outputs can be registered without a cycle of lag.
    always_comb begin
        sout_s       = 1'b0;
        sout_valid_s = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        load_ready_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                load_ready_s = 1'b1;
            end
            ST_SHIFT: begin
                sout_s       = shreg_s[WIDTH-1];
                sout_valid_s = 1'b1;
                busy_s       = 1'b1;
`ifdef PISO_PARITY_EN
                done_s       = 1'b0;
                load_ready_s = 1'b0;
`else
                done_s       = (cnt_s == {CNT_W{1'b0}});
                load_ready_s = (cnt_s == {CNT_W{1'b0}});
`endif
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                sout_s       = parity_s;
                sout_valid_s = 1'b1;
                busy_s       = 1'b1;
                done_s       = 1'b1;
                load_ready_s = 1'b1;
            end
`endif
            default: begin
                load_ready_s = 1'b0;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
`ifdef PISO_PARITY_EN
            parity_r   <= 1'b0;
`endif
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            cnt_r      <= cnt_s;
`ifdef PISO_PARITY_EN
            parity_r   <= parity_s;
`endif
            sout       <= sout_s;
            sout_valid <= sout_valid_s;
            busy       <= busy_s;
            done       <= done_s;
            load_ready <= load_ready_s;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ============================================================================
// tb_piso_serializer
// ----------------------------------------------------------------------------
// Directed self-checking bench for piso_serializer. Instantiates an 8-bit
// and a 2-bit serializer. Outputs are sampled on the falling clock edge;
// inputs are changed on the falling edge as well.
// ============================================================================
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int NB  = 9;
    localparam int NB2 = 3;
`else
    localparam int NB  = 8;
    localparam int NB2 = 2;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    logic [1:0] din2;
    logic       load_valid2;
    logic       load_ready2;
    logic       sout2;
    logic       sout_valid2;
    logic       busy2;
    logic       done2;

    int checks;
    int errors;

    piso_serializer #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    piso_serializer #(.WIDTH(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .load_valid (load_valid2),
        .load_ready (load_ready2),
        .sout       (sout2),
        .sout_valid (sout_valid2),
        .busy       (busy2),
        .done       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected serial bit j of an 8-bit word (j == 8 is the parity bit).
    function automatic logic exp_bit8(input logic [7:0] w, input int j);
        if (j < 8) return w[7 - j];
        else       return ^w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold got %b exp 00000", {sout, sout_valid, busy, done, load_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release got %b exp 00001", {sout, sout_valid, busy, done, load_ready});
        end
        checks++;
        if ({sout2, sout_valid2, busy2, done2, load_ready2} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release_w2 got %b exp 00001", {sout2, sout_valid2, busy2, done2, load_ready2});
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        din = w;
        load_valid = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (k == 0) begin
                load_valid = 1'b0;
                din = 8'h00;
            end
            checks++;
            if (sout !== exp_bit8(w, k)) begin
                errors++;
                $display("FAIL single_sout k=%0d got %b exp %b", k, sout, exp_bit8(w, k));
            end
            checks++;
            if ({sout_valid, busy} !== 2'b11) begin
                errors++;
                $display("FAIL single_valid_busy k=%0d got %b exp 11", k, {sout_valid, busy});
            end
            checks++;
            if (done !== (k == NB - 1)) begin
                errors++;
                $display("FAIL single_done k=%0d got %b exp %b", k, done, (k == NB - 1));
            end
            checks++;
            if (load_ready !== (k == NB - 1)) begin
                errors++;
                $display("FAIL single_ready k=%0d got %b exp %b", k, load_ready, (k == NB - 1));
            end
        end
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL single_idle got %b exp 00001", {sout, sout_valid, busy, done, load_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        int dones;
        dones = 0;
        din = 8'hFF;
        load_valid = 1'b1;
        for (int k = 0; k < 2 * NB; k++) begin
            @(negedge clk);
            w = (k < NB) ? 8'hFF : 8'h00;
            checks++;
            if (sout !== exp_bit8(w, k % NB)) begin
                errors++;
                $display("FAIL b2b_sout k=%0d got %b exp %b", k, sout, exp_bit8(w, k % NB));
            end
            checks++;
            if (sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_valid k=%0d got %b exp 1", k, sout_valid);
            end
            checks++;
            if (done !== ((k % NB) == NB - 1)) begin
                errors++;
                $display("FAIL b2b_done k=%0d got %b exp %b", k, done, ((k % NB) == NB - 1));
            end
            if (done === 1'b1) dones++;
            if (k == NB - 1) din = 8'h00;
            if (k == 2 * NB - 1) load_valid = 1'b0;
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d exp 2", dones);
        end
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy, load_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_idle got %b exp 0001", {sout, sout_valid, busy, load_ready});
        end
    endtask

    task automatic test_ignore();
        logic [7:0] w;
        int dones;
        dones = 0;
        w = 8'h3C;
        din = w;
        load_valid = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            checks++;
            if (sout !== exp_bit8(w, k) || sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL ignore_sout k=%0d got %b/%b exp %b/1", k, sout, sout_valid, exp_bit8(w, k));
            end
            if (done === 1'b1) dones++;
            // Requests while not ready must be dropped.
            if (k == 2 || k == 4) begin
                load_valid = 1'b1;
                din = 8'hFF;
            end else begin
                load_valid = 1'b0;
                din = 8'h00;
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_done_count got %0d exp 1", dones);
        end
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy, load_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL ignore_idle got %b exp 0001", {sout, sout_valid, busy, load_ready});
        end
    endtask

    task automatic test_parity();
        logic [7:0] w;
        w = 8'h07;
        din = w;
        load_valid = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (k == 0) load_valid = 1'b0;
            checks++;
            if (sout !== exp_bit8(w, k) || done !== (k == NB - 1)) begin
                errors++;
                $display("FAIL parity_stream k=%0d got %b/%b exp %b/%b", k, sout, done, exp_bit8(w, k), (k == NB - 1));
            end
        end
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL parity_idle got %b exp 000", {sout, sout_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'h81;
        din = w;
        load_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) load_valid = 1'b0;
            checks++;
            if (sout !== exp_bit8(w, k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_pre k=%0d got %b/%b exp %b/1", k, sout, busy, exp_bit8(w, k));
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_async got %b exp 00000", {sout, sout_valid, busy, done, load_ready});
        end
        @(negedge clk);
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_hold got %b exp 00000", {sout, sout_valid, busy, done, load_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sout_valid, busy, load_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_release got %b exp 001", {sout_valid, busy, load_ready});
        end
        din = w;
        load_valid = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (k == 0) load_valid = 1'b0;
            checks++;
            if (sout !== exp_bit8(w, k) || sout_valid !== 1'b1 || done !== (k == NB - 1)) begin
                errors++;
                $display("FAIL rstmid_reload k=%0d got %b%b%b exp %b1%b", k, sout, sout_valid, done, exp_bit8(w, k), (k == NB - 1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_width2();
        logic [1:0] w;
        logic       e;
        int         j;
        din2 = 2'b10;
        load_valid2 = 1'b1;
        for (int k = 0; k < 2 * NB2; k++) begin
            @(negedge clk);
            w = (k < NB2) ? 2'b10 : 2'b01;
            j = k % NB2;
            e = (j < 2) ? w[1 - j] : ^w;
            checks++;
            if (sout2 !== e || sout_valid2 !== 1'b1) begin
                errors++;
                $display("FAIL w2_sout k=%0d got %b/%b exp %b/1", k, sout2, sout_valid2, e);
            end
            checks++;
            if (done2 !== (j == NB2 - 1)) begin
                errors++;
                $display("FAIL w2_done k=%0d got %b exp %b", k, done2, (j == NB2 - 1));
            end
            if (k == NB2 - 1) din2 = 2'b01;
            if (k == 2 * NB2 - 1) load_valid2 = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({sout2, sout_valid2, busy2, load_ready2} !== 4'b0001) begin
            errors++;
            $display("FAIL w2_idle got %b exp 0001", {sout2, sout_valid2, busy2, load_ready2});
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        din = 8'h00;
        load_valid = 1'b0;
        din2 = 2'b00;
        load_valid2 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_parity();
        test_reset_mid();
        test_width2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock, MSB first.
- Transmit-side counterpart to the team's DFF-based serial capture logic.
- Built on a reset-to-zero shift register, a bit counter and a small FSM.
- Sits between the parallel datapath and a single-wire serial link.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  parallel word to transmit
- load_valid  input  1  din is valid this cycle
- load_ready  output  1  block can accept a word this cycle
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a data (or parity) bit this cycle
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse on the final bit of a word

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk, rising edge.
- While rst=1 the block is held as follows:
  - sout=0, sout_valid=0, busy=0, done=0, load_ready=0.
  - Shift register = 0, counter = 0, state = IDLE.
- The first rising edge after rst deasserts leaves the block in IDLE with load_ready=1.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- IDLE:
  - load_ready=1, sout=0, sout_valid=0, busy=0.
  - On an edge with load_valid&&load_ready: shreg<=din, cnt<=WIDTH-1, state<=SHIFT.
- SHIFT:
  - sout=shreg[WIDTH-1], sout_valid=1, busy=1.
  - Each edge: shreg<=shreg<<1 (zero-filled), cnt<=cnt-1.
  - Last bit is the cycle with cnt==0. In that cycle: done=1 and load_ready=1.
  - If load_valid=1 in the last-bit cycle: reload din and stay in SHIFT. The next word's MSB appears the next cycle with no idle gap (back-to-back streaming).
  - If load_valid=0 in the last-bit cycle: state<=IDLE.
- load_ready=0 in SHIFT except on the last-bit cycle. load_valid while load_ready=0 is ignored; din is not sampled.
- Latency: MSB appears on sout the cycle after the accepting edge. WIDTH data cycles per word.
- din is sampled only on the accepting edge; later changes to din do not affect the transfer.
- Reset mid-transfer aborts immediately (asynchronously):
  - sout/sout_valid drop to 0 with no done pulse.
  - The partial word is discarded.
- Counter never wraps: it is reloaded on every accept, and counting below zero is unreachable.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle: sout = even parity (XOR of the accepted word), sout_valid=1, busy=1.
  - done and the load_ready back-to-back window move from the last data bit to the PARITY cycle.
  - Each word takes WIDTH+1 cycles.
- Undefined: no PARITY state. Behaviour is exactly as above (WIDTH cycles per word, done on the last data bit).
- The port list is identical in both builds.

Test Plan:
- Reset release then load 8'hA5 in one cycle → sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept. sout_valid=1 and busy=1 throughout; done=1 only on the 8th bit. Next cycle: IDLE, sout=0.
- Load 8'hFF with load_valid held high and din switched to 8'h00 on the last-bit cycle → 8 ones immediately followed by 8 zeros, sout_valid continuous (16 cycles), two done pulses, no gap.
- Load 8'h3C, pulse load_valid with din=8'hFF on bits 3 and 5 → those requests are ignored; output stays 0,0,1,1,1,1,0,0 and exactly one done pulse occurs.
- Load 8'h81, assert rst asynchronously mid-cycle after bit 4 → sout, sout_valid and busy drop to 0 immediately with no done pulse. After release, load_ready=1 and a fresh load of 8'h81 shifts correctly.
- PISO_PARITY_EN defined: load 8'hA5 → 8 data bits then parity bit 0, done on the 9th cycle. Load 8'h07 → parity bit 1.
- WIDTH=2: load 2'b10 → sout 1,0, done on the 2nd bit. Back-to-back 2'b01 → 0,1 with no gap.
